// File: rtl/line_walker.sv
// line_walker: all-octant integer Bresenham line generator. It emits one
// pixel per valid/ready handshake, from (x0,y0) through (x1,y1) inclusive.
module line_walker #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] x0,
    input  logic [CW-1:0] y0,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] y1,
    input  logic          abort,
    output logic          busy,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic          pix_last,
    output logic          done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [CW-1:0]        r_x0, r_y0, r_x1, r_y1;
    logic [CW:0]          r_dx, r_dy;
    logic                 r_sx_neg, r_sy_neg;
    logic signed [CW+1:0] r_err;
    logic [CW-1:0]        r_x, r_y;
    logic                 r_last, r_valid, r_busy, r_done;

    logic [CW-1:0]        w_x0_nxt, w_y0_nxt, w_x1_nxt, w_y1_nxt;
    logic [CW:0]          w_dx_nxt, w_dy_nxt;
    logic                 w_sx_neg_nxt, w_sy_neg_nxt;
    logic signed [CW+1:0] w_err_nxt;
    logic [CW-1:0]        w_x_nxt, w_y_nxt;
    logic                 w_last_nxt, w_valid_nxt, w_busy_nxt, w_done_nxt;

    logic [CW:0]          w_dx_abs, w_dy_abs;
    logic signed [CW+1:0] w_err_init;
    logic signed [CW+2:0] w_e2, w_dx_s, w_dy_s, w_sub, w_add, w_err_wide;
    logic                 w_step_x, w_step_y, w_hs;
    logic [CW-1:0]        w_x_walk, w_y_walk;

    // Setup arithmetic works on the captured endpoints, not the live inputs.
    always_comb begin
        w_dx_abs   = (r_x1 >= r_x0) ? ({1'b0, r_x1} - {1'b0, r_x0})
                                    : ({1'b0, r_x0} - {1'b0, r_x1});
        w_dy_abs   = (r_y1 >= r_y0) ? ({1'b0, r_y1} - {1'b0, r_y0})
                                    : ({1'b0, r_y0} - {1'b0, r_y1});
        w_err_init = $signed({1'b0, w_dx_abs}) - $signed({1'b0, w_dy_abs});
    end

    // Step decision: both tests use the old error term; their updates add up.
    always_comb begin
        w_dx_s     = $signed({2'b00, r_dx});
        w_dy_s     = $signed({2'b00, r_dy});
        w_e2       = $signed({r_err, 1'b0});
        w_step_x   = (w_e2 > -w_dy_s);
        w_step_y   = (w_e2 < w_dx_s);
        w_sub      = w_step_x ? w_dy_s : '0;
        w_add      = w_step_y ? w_dx_s : '0;
        w_err_wide = $signed({r_err[CW+1], r_err}) - w_sub + w_add;
        w_x_walk   = w_step_x ? (r_sx_neg ? r_x - CW'(1) : r_x + CW'(1)) : r_x;
        w_y_walk   = w_step_y ? (r_sy_neg ? r_y - CW'(1) : r_y + CW'(1)) : r_y;
        w_hs       = r_valid && pix_ready;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_x0_nxt     = r_x0;
        w_y0_nxt     = r_y0;
        w_x1_nxt     = r_x1;
        w_y1_nxt     = r_y1;
        w_dx_nxt     = r_dx;
        w_dy_nxt     = r_dy;
        w_sx_neg_nxt = r_sx_neg;
        w_sy_neg_nxt = r_sy_neg;
        w_err_nxt    = r_err;
        w_x_nxt      = r_x;
        w_y_nxt      = r_y;
        w_last_nxt   = r_last;
        w_valid_nxt  = r_valid;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_x0_nxt    = x0;
                    w_y0_nxt    = y0;
                    w_x1_nxt    = x1;
                    w_y1_nxt    = y1;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_dx_nxt     = w_dx_abs;
                w_dy_nxt     = w_dy_abs;
                w_sx_neg_nxt = (r_x1 < r_x0);
                w_sy_neg_nxt = (r_y1 < r_y0);
                w_err_nxt    = w_err_init;
                w_x_nxt      = r_x0;
                w_y_nxt      = r_y0;
                w_last_nxt   = (r_x0 == r_x1) && (r_y0 == r_y1);
                w_valid_nxt  = 1'b1;
                w_state_nxt  = STEP;
            end
            STEP: begin
                if (w_hs) begin
                    if (r_last) begin
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_err_nxt  = w_err_wide[CW+1:0];
                        w_x_nxt    = w_x_walk;
                        w_y_nxt    = w_y_walk;
                        w_last_nxt = (w_x_walk == r_x1) && (w_y_walk == r_y1);
                    end
                end
            end
            default: begin
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase

        // Abort overrides any handshake or completion in the same cycle.
        if (abort && (r_state != IDLE)) begin
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_x0     <= '0;
            r_y0     <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_err    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_last   <= 1'b0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_x0     <= w_x0_nxt;
            r_y0     <= w_y0_nxt;
            r_x1     <= w_x1_nxt;
            r_y1     <= w_y1_nxt;
            r_dx     <= w_dx_nxt;
            r_dy     <= w_dy_nxt;
            r_sx_neg <= w_sx_neg_nxt;
            r_sy_neg <= w_sy_neg_nxt;
            r_err    <= w_err_nxt;
            r_x      <= w_x_nxt;
            r_y      <= w_y_nxt;
            r_last   <= w_last_nxt;
            r_valid  <= w_valid_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign busy      = r_busy;
    assign pix_valid = r_valid;
    assign pix_x     = r_x;
    assign pix_y     = r_y;
    assign pix_last  = r_last;
    assign done      = r_done;

endmodule
